// File: rtl/seg_display_arbiter.sv
// Round-robin owner of a shared 7-segment display: LOAD snapshots the winner, SHOW holds it for a fixed dwell, GAP blanks between owners.
// Grant one cycle after a request is sampled in IDLE; no backpressure, a request that drops is either an abort (owner) or lost (non-owner).
module seg_display_arbiter #(
    parameter int requesters   = 4,
    parameter int digits       = 4,
    parameter int dwell_cycles = 12000000,
    parameter int gap_cycles   = 1200000
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [requesters-1:0]            req_i,
    input  logic [requesters*digits*4-1:0]   data_i,
    output logic [requesters-1:0]            grant_o,
    output logic [requesters-1:0]            done_o,
    output logic [digits*4-1:0]              data_o,
    output logic                             blank_o,
    output logic                             busy_o
);

    localparam int DW      = digits * 4;
    localparam int PW      = $clog2(requesters);
    localparam int CNT_MAX = (dwell_cycles > gap_cycles) ? dwell_cycles : gap_cycles;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(dwell_cycles - 1);
    localparam logic [CW-1:0] GAP_LOAD   = (gap_cycles > 0) ? CW'(gap_cycles - 1) : '0;

    typedef enum logic [1:0] {IDLE, LOAD, SHOW, GAP} state_t;

    state_t                  state, state_n;
    logic [PW-1:0]           ptr, ptr_n, owner, owner_n, win;
    logic [CW-1:0]           cnt, cnt_n;
    logic [requesters-1:0]   grant_n, done_n;
    logic [DW-1:0]           data_n;
    logic                    blank_n, any_req, do_arb;
    int                      sum;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        sum     = 0;
        for (int i = 0; i < requesters; i++) begin
            sum = int'(ptr) + i;
            if (sum >= requesters) sum = sum - requesters;
            if (!any_req && req_i[sum]) begin
                any_req = 1'b1;
                win     = PW'(sum);
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        grant_n = grant_o;
        done_n  = '0;
        data_n  = data_o;
        blank_n = blank_o;
        do_arb  = 1'b0;
        case (state)
            IDLE: do_arb = 1'b1;
            LOAD: begin
                data_n  = data_i[int'(owner)*DW +: DW];
                cnt_n   = DWELL_LOAD;
                blank_n = 1'b0;
                state_n = SHOW;
            end
            SHOW: begin
                if (!req_i[owner] || cnt == '0) begin
                    grant_n = '0;
                    if (req_i[owner]) done_n[owner] = 1'b1;
                    if (gap_cycles == 0) begin
                        do_arb = 1'b1;
                    end else begin
                        state_n = GAP;
                        cnt_n   = GAP_LOAD;
                        blank_n = 1'b1;
                        data_n  = '0;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    // Blank covers only the gap itself; a new owner unblanks from LOAD.
                    blank_n = 1'b0;
                    do_arb  = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (do_arb) begin
            if (any_req) begin
                state_n      = LOAD;
                grant_n      = '0;
                grant_n[win] = 1'b1;
                owner_n      = win;
                ptr_n        = (int'(win) == requesters - 1) ? '0 : win + 1'b1;
            end else begin
                state_n = IDLE;
                blank_n = 1'b1;
                data_n  = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            grant_o <= '0;
            done_o  <= '0;
            data_o  <= '0;
            blank_o <= 1'b1;
            busy_o  <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            cnt     <= cnt_n;
            grant_o <= grant_n;
            done_o  <= done_n;
            data_o  <= data_n;
            blank_o <= blank_n;
            busy_o  <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: instance A (gap 2) and instance B (gap 0), 3 clients, dwell 8.
module tb_seg_display_arbiter;

    localparam int DWELL = 8;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [2:0]  req_a, req_b;
    logic [47:0] data_a, data_b;
    logic [2:0]  grant_a, done_a, grant_b, done_b;
    logic [15:0] dout_a, dout_b;
    logic        blank_a, busy_a, blank_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    seg_display_arbiter #(.requesters(3), .digits(4), .dwell_cycles(DWELL), .gap_cycles(2)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .data_i(data_a),
        .grant_o(grant_a), .done_o(done_a), .data_o(dout_a), .blank_o(blank_a), .busy_o(busy_a)
    );

    seg_display_arbiter #(.requesters(3), .digits(4), .dwell_cycles(DWELL), .gap_cycles(0)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .data_i(data_b),
        .grant_o(grant_b), .done_o(done_b), .data_o(dout_b), .blank_o(blank_b), .busy_o(busy_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d got %h want %h", name, cyc, got, exp);
        end
    endtask

    // Model: owner index + age since grant, and gap cycles remaining.
    int          m_own[2], m_age[2], m_gap[2], m_ptr[2];
    logic [2:0]  e_grant[2], e_done[2];
    logic [15:0] e_data[2];
    logic        e_blank[2], e_busy[2];

    task automatic model_step(input int u, input logic rst, input logic [2:0] req,
                              input logic [47:0] data, input int gapc);
        bit arb, from_gap;
        int k;
        arb = 0; from_gap = 0; k = -1;
        e_done[u] = 3'b000;
        if (rst) begin
            m_own[u] = -1; m_age[u] = 0; m_gap[u] = 0; m_ptr[u] = 0;
            e_data[u] = 16'h0; e_blank[u] = 1'b1;
        end else begin
            if (m_own[u] >= 0) begin
                if (m_age[u] == 0) begin
                    e_data[u]  = data[m_own[u]*16 +: 16];
                    e_blank[u] = 1'b0;
                    m_age[u]   = 1;
                end else if (!req[m_own[u]] || m_age[u] == DWELL) begin
                    if (req[m_own[u]]) e_done[u] = 3'(1 << m_own[u]);
                    m_own[u] = -1;
                    if (gapc > 0) begin
                        m_gap[u] = gapc; e_blank[u] = 1'b1; e_data[u] = 16'h0;
                    end else arb = 1;
                end else m_age[u]++;
            end else if (m_gap[u] > 0) begin
                m_gap[u]--;
                if (m_gap[u] == 0) begin arb = 1; from_gap = 1; end
            end else arb = 1;
            if (arb) begin
                for (int i = 0; i < 3; i++)
                    if (k < 0 && req[(m_ptr[u] + i) % 3]) k = (m_ptr[u] + i) % 3;
                if (k >= 0) begin
                    m_own[u] = k; m_age[u] = 0; m_ptr[u] = (k + 1) % 3;
                    if (from_gap) e_blank[u] = 1'b0;
                end else begin
                    e_blank[u] = 1'b1; e_data[u] = 16'h0;
                end
            end
        end
        e_grant[u] = (m_own[u] >= 0) ? 3'(1 << m_own[u]) : 3'b000;
        e_busy[u]  = (m_own[u] >= 0) || (m_gap[u] > 0);
    endtask

    always @(posedge clk) begin
        model_step(0, rst_a, req_a, data_a, 2);
        model_step(1, rst_b, req_b, data_b, 0);
        cyc++;
    end

    always @(negedge clk) begin
        check("A.grant", 32'(grant_a), 32'(e_grant[0]));
        check("A.done",  32'(done_a),  32'(e_done[0]));
        check("A.data",  32'(dout_a),  32'(e_data[0]));
        check("A.blank", 32'(blank_a), 32'(e_blank[0]));
        check("A.busy",  32'(busy_a),  32'(e_busy[0]));
        check("B.grant", 32'(grant_b), 32'(e_grant[1]));
        check("B.done",  32'(done_b),  32'(e_done[1]));
        check("B.data",  32'(dout_b),  32'(e_data[1]));
        check("B.blank", 32'(blank_b), 32'(e_blank[1]));
        check("B.busy",  32'(busy_b),  32'(e_busy[1]));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    logic [2:0] own[4];
    int         at[4];
    int         n;
    int         blank_hi;
    logic [2:0] prev;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; req_a = '0; req_b = '0; data_a = '0; data_b = '0;
        tick(); tick();
        check("rst.grant", 32'(grant_a), 32'h0);
        check("rst.done",  32'(done_a),  32'h0);
        check("rst.data",  32'(dout_a),  32'h0);
        check("rst.blank", 32'(blank_a), 32'h1);
        check("rst.busy",  32'(busy_a),  32'h0);

        // single request from client 1
        rst_a = 1'b0; data_a[16 +: 16] = 16'h1234; req_a = 3'b010;
        tick();
        check("single.grant_latency", 32'(grant_a), 32'h2);
        check("single.load_blank",    32'(blank_a), 32'h1);
        repeat (DWELL) begin
            tick();
            check("single.show_data",  32'(dout_a),  32'h1234);
            check("single.show_blank", 32'(blank_a), 32'h0);
        end
        tick();
        check("single.done",       32'(done_a),  32'h2);
        check("single.grant_fall", 32'(grant_a), 32'h0);
        check("single.gap1_blank", 32'(blank_a), 32'h1);
        tick();
        check("single.gap2_blank", 32'(blank_a), 32'h1);
        check("single.done_once",  32'(done_a),  32'h0);
        tick();
        check("single.regrant", 32'(grant_a), 32'h2);

        // round robin from a fresh pointer
        req_a = '0; rst_a = 1'b1; data_a[0 +: 16] = 16'hAAAA;
        tick();
        rst_a = 1'b0; req_a = 3'b111;
        n = 0; prev = '0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            tick();
            if (grant_a != 3'b000 && prev == 3'b000) begin
                own[n] = grant_a; at[n] = cyc; n++;
            end
            prev = grant_a;
        end
        check("rr.grants_seen", 32'(n), 32'd4);
        check("rr.order0", 32'(own[0]), 32'h1);
        check("rr.order1", 32'(own[1]), 32'h2);
        check("rr.order2", 32'(own[2]), 32'h4);
        check("rr.order3", 32'(own[3]), 32'h1);
        check("rr.space01", 32'(at[1] - at[0]), 32'd11);
        check("rr.space12", 32'(at[2] - at[1]), 32'd11);
        check("rr.space23", 32'(at[3] - at[2]), 32'd11);

        // snapshot: client 0 data changes mid-SHOW
        tick();
        check("snap.first", 32'(dout_a), 32'hAAAA);
        data_a[0 +: 16] = 16'h5555;
        repeat (DWELL - 1) begin
            tick();
            check("snap.hold", 32'(dout_a), 32'hAAAA);
        end
        tick();
        check("snap.gap_clear", 32'(dout_a), 32'h0);
        check("snap.done",      32'(done_a), 32'h1);

        // abort: client 0 drops at SHOW cycle 3, client 1 pending
        req_a = '0; rst_a = 1'b1;
        tick();
        rst_a = 1'b0; req_a = 3'b011;
        tick();
        check("abort.grant0", 32'(grant_a), 32'h1);
        tick(); tick(); tick();
        req_a = 3'b010;
        tick();
        check("abort.grant_clear", 32'(grant_a), 32'h0);
        check("abort.no_done",     32'(done_a),  32'h0);
        check("abort.gap_blank",   32'(blank_a), 32'h1);
        tick();
        check("abort.gap2_grant", 32'(grant_a), 32'h0);
        tick();
        check("abort.next_owner", 32'(grant_a), 32'h2);

        // reset during SHOW cycle 4 of client 1
        repeat (4) tick();
        rst_a = 1'b1;
        tick();
        check("midrst.grant", 32'(grant_a), 32'h0);
        check("midrst.done",  32'(done_a),  32'h0);
        check("midrst.data",  32'(dout_a),  32'h0);
        check("midrst.blank", 32'(blank_a), 32'h1);
        check("midrst.busy",  32'(busy_a),  32'h0);
        rst_a = 1'b0; req_a = 3'b111;
        tick();
        check("midrst.first_grant", 32'(grant_a), 32'h1);
        req_a = '0;

        // gap disabled: 0 -> 2 back to back, no blanking after first grant
        rst_b = 1'b0; req_b = 3'b101;
        data_b[0 +: 16] = 16'hC0C0; data_b[32 +: 16] = 16'h2222;
        n = 0; prev = '0; blank_hi = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (n > 0 && blank_b) blank_hi++;
            if (grant_b != 3'b000 && grant_b != prev && n < 4) begin
                own[n] = grant_b; at[n] = cyc; n++;
            end
            prev = grant_b;
        end
        check("nogap.grants_seen", 32'(n), 32'd4);
        check("nogap.first", 32'(own[0]), 32'h1);
        check("nogap.second", 32'(own[1]), 32'h4);
        check("nogap.space", 32'(at[1] - at[0]), 32'd9);
        check("nogap.blank_never", 32'(blank_hi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
